// File: rtl/mnist_frame_grabber.sv
// mnist_frame_grabber
// Crops a centred (16*OUT_DIM)-square window from an 8-bit grayscale camera stream and
// box-averages it in 16x16 blocks into an OUT_DIM x OUT_DIM image. The image is held in a
// double-buffered memory: capture fills the back bank while software reads the front bank.
//
// Ports:
//   clk_clk        system clock (camera stream is synchronous to it)
//   reset_reset_n  synchronous active-low reset
//   cam_valid      cam_pixel valid this cycle
//   cam_sof        start of frame, qualified by cam_valid; marks pixel (0,0)
//   cam_pixel      grayscale pixel, raster order
//   invert         store 255-avg instead of avg
//   freeze         discard completed frames (no bank swap); sampled only in COMMIT
//   read_address   front-bank byte address, row-major
//   pixel          registered read data, 1-cycle latency; 0 for out-of-range addresses
//   frame_count    committed frames, wrapping
//   busy           high while capturing
module mnist_frame_grabber #(
   parameter int unsigned IMG_W   = 640,
   parameter int unsigned IMG_H   = 480,
   parameter int unsigned X0      = 96,
   parameter int unsigned Y0      = 16,
   parameter int unsigned OUT_DIM = 28
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        cam_valid,
   input  logic        cam_sof,
   input  logic [7:0]  cam_pixel,
   input  logic        invert,
   input  logic        freeze,
   input  logic [11:0] read_address,
   output logic [7:0]  pixel,
   output logic [7:0]  frame_count,
   output logic        busy
);

   localparam int unsigned Win  = 16 * OUT_DIM;
   localparam int unsigned Npix = OUT_DIM * OUT_DIM;
   localparam int unsigned Bw   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int unsigned Aw   = (Npix > 1) ? $clog2(Npix) : 1;

   localparam logic [9:0]    XLo   = 10'(X0);
   localparam logic [9:0]    XHi   = 10'(X0 + Win);
   localparam logic [9:0]    XLast = 10'(IMG_W - 1);
   localparam logic [8:0]    YLo   = 9'(Y0);
   localparam logic [8:0]    YHi   = 9'(Y0 + Win);
   localparam logic [8:0]    YLast = 9'(IMG_H - 1);
   localparam logic [Bw-1:0] BLast = Bw'(OUT_DIM - 1);
   localparam logic [Aw-1:0] DimA  = Aw'(OUT_DIM);
   localparam logic [11:0]   NpixA = 12'(Npix);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCapture = 2'd1;
   localparam logic [1:0] StCommit  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [9:0]    x_q, x_d, cur_x, dx;
   logic [8:0]    y_q, y_d, cur_y, dy;
   logic          fb_q, fb_d;
   logic [7:0]    fc_q, fc_d;
   logic [7:0]    pixel_q;
   logic [15:0]   acc_q [OUT_DIM];
   logic [15:0]   acc_sum;
   logic          sof_hit, take, in_win, blk_done, wr_en;
   logic [Bw-1:0] bx, by;
   logic [Aw-1:0] waddr;
   logic [7:0]    avg, wr_data;

   // Two banks; bank fb_q is the front (read) bank, ~fb_q the back (capture) bank.
   logic [7:0] mem [2][Npix];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      fb_d    = fb_q;
      fc_d    = fc_q;

      // A start-of-frame pixel is itself pixel (0,0), whether it starts or restarts a frame.
      sof_hit = cam_valid && cam_sof && (state_q != StCommit);
      take    = cam_valid && ((state_q == StCapture) || sof_hit);
      cur_x   = sof_hit ? 10'd0 : x_q;
      cur_y   = sof_hit ? 9'd0 : y_q;

      in_win   = (cur_x >= XLo) && (cur_x < XHi) && (cur_y >= YLo) && (cur_y < YHi);
      dx       = cur_x - XLo;
      dy       = cur_y - YLo;
      bx       = Bw'(dx >> 4);
      by       = Bw'(dy >> 4);
      blk_done = in_win && (dx[3:0] == 4'hf) && (dy[3:0] == 4'hf);

      // On a restart the stale accumulator is treated as already cleared.
      acc_sum = (sof_hit ? 16'd0 : acc_q[bx]) + {8'd0, cam_pixel};
      avg     = acc_sum[15:8];
      wr_data = invert ? (8'hff - avg) : avg;
      waddr   = Aw'(by) * DimA + Aw'(bx);
      wr_en   = take && blk_done;

      if (take) begin
         state_d = StCapture;
         if (cur_x == XLast) begin
            x_d = 10'd0;
            y_d = (cur_y == YLast) ? 9'd0 : cur_y + 9'd1;
         end else begin
            x_d = cur_x + 10'd1;
            y_d = cur_y;
         end
         if (wr_en && (bx == BLast) && (by == BLast)) begin
            state_d = StCommit;
         end
      end

      if (state_q == StCommit) begin
         state_d = StIdle;
         if (!freeze) begin
            fb_d = ~fb_q;
            fc_d = fc_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         fb_q    <= 1'b0;
         fc_q    <= '0;
         pixel_q <= '0;
         for (int i = 0; i < int'(OUT_DIM); i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fb_q    <= fb_d;
         fc_q    <= fc_d;
         // Uses the pre-swap bank, so a read in the COMMIT cycle still sees the old frame.
         pixel_q <= (read_address < NpixA) ? mem[fb_q][Aw'(read_address)] : 8'd0;
         if (sof_hit) begin
            for (int i = 0; i < int'(OUT_DIM); i++) begin
               acc_q[i] <= '0;
            end
         end
         if (take && in_win) begin
            acc_q[bx] <= blk_done ? 16'd0 : acc_sum;
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset_n && wr_en) begin
         mem[~fb_q][waddr] <= wr_data;
      end
   end

   assign pixel       = pixel_q;
   assign frame_count = fc_q;
   assign busy        = (state_q == StCapture);

endmodule

// File: tb/tb_mnist_frame_grabber.sv
// Directed bench for mnist_frame_grabber, built with a reduced geometry (3x3 output,
// 48x48 window inside a 56x52 frame) so that full frames stay short.
module tb_mnist_frame_grabber;

   localparam int ImgW = 56;
   localparam int ImgH = 52;
   localparam int X0   = 4;
   localparam int Y0   = 2;
   localparam int Dim  = 3;
   localparam int Win  = 16 * Dim;
   localparam int Npix = Dim * Dim;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic        cam_valid;
   logic        cam_sof;
   logic [7:0]  cam_pixel;
   logic        invert;
   logic        freeze;
   logic [11:0] read_address;
   logic [7:0]  pixel;
   logic [7:0]  frame_count;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int exp_img [Npix];
   int exp_fc = 0;

   mnist_frame_grabber #(
      .IMG_W   (ImgW),
      .IMG_H   (ImgH),
      .X0      (X0),
      .Y0      (Y0),
      .OUT_DIM (Dim)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .cam_valid     (cam_valid),
      .cam_sof       (cam_sof),
      .cam_pixel     (cam_pixel),
      .invert        (invert),
      .freeze        (freeze),
      .read_address  (read_address),
      .pixel         (pixel),
      .frame_count   (frame_count),
      .busy          (busy)
   );

   always #5 clk_clk = ~clk_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   // mode 0: every pixel = uval. mode 1: block k gets 20k, +3 on odd (lx+ly); outside = 255.
   function automatic int pix_at(input int mode, input int uval, input int x, input int y);
      int dx, dy, k;
      if (mode == 0) return uval;
      if (x >= X0 && x < X0 + Win && y >= Y0 && y < Y0 + Win) begin
         dx = x - X0;
         dy = y - Y0;
         k  = (dy / 16) * Dim + (dx / 16);
         return k * 20 + ((((dx + dy) % 2) != 0) ? 3 : 0);
      end
      return 255;
   endfunction

   // Block average: uniform -> uval; pattern -> (256*20k + 128*3) >> 8 = 20k + 1.
   function automatic int exp_for(input int mode, input int uval, input bit inv, input int k);
      int avg;
      avg = (mode == 0) ? uval : k * 20 + 1;
      return inv ? 255 - avg : avg;
   endfunction

   task automatic commit_model(input int mode, input int uval, input bit inv);
      exp_fc = (exp_fc + 1) % 256;
      for (int k = 0; k < Npix; k++) exp_img[k] = exp_for(mode, uval, inv, k);
   endtask

   // Streams one frame in raster order. Stops before pixel (stop_x, stop_y) when stop_y >= 0.
   // With probe_addr >= 0, read_address is held there and the reads around COMMIT are checked.
   task automatic send_frame(input int mode, input int uval, input bit inv, input bit frz,
                             input bit gaps, input int stop_y, input int stop_x,
                             input int probe_addr, input int probe_old, input int probe_new);
      int post;
      post   = 0;
      invert = inv;
      freeze = frz;
      if (probe_addr >= 0) read_address = 12'(probe_addr);
      for (int y = 0; y < ImgH; y++) begin
         for (int x = 0; x < ImgW; x++) begin
            if (y == stop_y && x == stop_x) begin
               cam_valid = 1'b0;
               cam_sof   = 1'b0;
               return;
            end
            if (gaps && (x % 7 == 3)) begin
               cam_valid = 1'b0;
               cam_sof   = 1'b0;
               tick();
            end
            cam_valid = 1'b1;
            cam_sof   = (x == 0 && y == 0);
            cam_pixel = 8'(pix_at(mode, uval, x, y));
            tick();
            if (x == 0 && y == 0) check("busy_after_sof", int'(busy), 1);
            if (post > 0) post++;
            if (probe_addr >= 0 && post == 2) check("read_in_commit_old", int'(pixel), probe_old);
            if (probe_addr >= 0 && post == 3) check("read_after_commit_new", int'(pixel), probe_new);
            if (x == X0 + Win - 1 && y == Y0 + Win - 1) begin
               check("busy_in_commit", int'(busy), 0);
               post = 1;
            end
         end
      end
      cam_valid = 1'b0;
      cam_sof   = 1'b0;
      tick();
   endtask

   // Back-to-back reads; the address changes before each sample, so a zero-latency path shows.
   task automatic read_all(input string tag);
      int addrs [Npix + 3];
      int exps  [Npix + 3];
      for (int k = 0; k < Npix; k++) begin
         addrs[k] = k;
         exps[k]  = exp_img[k];
      end
      addrs[Npix]     = Npix;
      addrs[Npix + 1] = 784;
      addrs[Npix + 2] = 4095;
      exps[Npix]      = 0;
      exps[Npix + 1]  = 0;
      exps[Npix + 2]  = 0;
      read_address = 12'(addrs[0]);
      for (int i = 0; i < Npix + 3; i++) begin
         tick();
         read_address = (i + 1 < Npix + 3) ? 12'(addrs[i + 1]) : 12'd0;
         check($sformatf("%s_addr%0d", tag, addrs[i]), int'(pixel), exps[i]);
      end
   endtask

   initial begin
      reset_reset_n = 1'b0;
      cam_valid     = 1'b0;
      cam_sof       = 1'b0;
      cam_pixel     = 8'd0;
      invert        = 1'b0;
      freeze        = 1'b0;
      read_address  = 12'd0;
      repeat (3) tick();
      check("reset_pixel", int'(pixel), 0);
      check("reset_frame_count", int'(frame_count), 0);
      check("reset_busy", int'(busy), 0);
      reset_reset_n = 1'b1;
      tick();

      // Pixels without sof in IDLE are ignored.
      for (int i = 0; i < 20; i++) begin
         cam_valid = 1'b1;
         cam_pixel = 8'(i);
         tick();
      end
      cam_valid = 1'b0;
      check("idle_busy", int'(busy), 0);
      check("idle_frame_count", int'(frame_count), 0);

      send_frame(0, 128, 1'b0, 1'b0, 1'b1, -1, 0, -1, 0, 0);
      commit_model(0, 128, 1'b0);
      check("u128_frame_count", int'(frame_count), exp_fc);
      read_all("u128");

      send_frame(0, 128, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(0, 128, 1'b1);
      check("u128inv_frame_count", int'(frame_count), exp_fc);
      read_all("u128inv");

      send_frame(0, 255, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(0, 255, 1'b0);
      read_all("u255");

      send_frame(0, 255, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(0, 255, 1'b1);
      read_all("u255inv");

      send_frame(1, 0, 1'b0, 1'b0, 1'b0, -1, 0, 4, exp_img[4], exp_for(1, 0, 1'b0, 4));
      commit_model(1, 0, 1'b0);
      check("pattern_frame_count", int'(frame_count), exp_fc);
      read_all("pattern");

      // Second frame completes under freeze: discarded, count unchanged.
      send_frame(0, 50, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(0, 50, 1'b0);
      check("pre_freeze_frame_count", int'(frame_count), exp_fc);
      send_frame(0, 200, 1'b0, 1'b1, 1'b0, -1, 0, -1, 0, 0);
      check("freeze_frame_count", int'(frame_count), exp_fc);
      read_all("freeze");

      // Frame A aborted mid-window by a new sof; only frame B commits.
      send_frame(0, 255, 1'b0, 1'b0, 1'b0, 25, 20, -1, 0, 0);
      check("abort_busy", int'(busy), 1);
      send_frame(1, 0, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(1, 0, 1'b0);
      check("abort_frame_count", int'(frame_count), exp_fc);
      read_all("abort");

      // Reset mid-frame: partial frame never commits.
      send_frame(0, 255, 1'b0, 1'b0, 1'b0, 25, 20, -1, 0, 0);
      reset_reset_n = 1'b0;
      read_address  = 12'd1;
      tick();
      check("midreset_pixel", int'(pixel), 0);
      check("midreset_frame_count", int'(frame_count), 0);
      check("midreset_busy", int'(busy), 0);
      reset_reset_n = 1'b1;
      exp_fc = 0;
      tick();
      check("after_reset_frame_count", int'(frame_count), 0);
      send_frame(0, 128, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0, 0);
      commit_model(0, 128, 1'b1);
      check("post_reset_frame_count", int'(frame_count), exp_fc);
      read_all("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
